// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: shared definitions for the RV M-extension multiply/divide unit.
//   - ctl (func3) operation encodings
//   - FSM state type
//   - operation latency constant (XLEN + 2 cycles from start to done)
//   - operand signedness helpers
package muldiv_unit_pkg;

    localparam logic [2:0] CTL_MUL    = 3'b000;
    localparam logic [2:0] CTL_MULH   = 3'b001;
    localparam logic [2:0] CTL_MULHSU = 3'b010;
    localparam logic [2:0] CTL_MULHU  = 3'b011;
    localparam logic [2:0] CTL_DIV    = 3'b100;
    localparam logic [2:0] CTL_DIVU   = 3'b101;
    localparam logic [2:0] CTL_REM    = 3'b110;
    localparam logic [2:0] CTL_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX,
        ST_DONE
    } state_e;

    localparam int unsigned DEFAULT_XLEN    = 32;
    // Cycles from the start cycle to the done cycle for an iterative operation.
    localparam int unsigned DEFAULT_LATENCY = DEFAULT_XLEN + 2;

    function automatic int unsigned op_latency(input int unsigned xlen);
        return xlen + 2;
    endfunction

    function automatic logic a_is_signed(input logic [2:0] op);
        return (op == CTL_MULH) || (op == CTL_MULHSU) || (op == CTL_DIV) || (op == CTL_REM);
    endfunction

    function automatic logic b_is_signed(input logic [2:0] op);
        return (op == CTL_MULH) || (op == CTL_DIV) || (op == CTL_REM);
    endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// muldiv_signfix: combinational sign handling for muldiv_unit.
//   a_in, b_in     : raw operands
//   a_sgn, b_sgn   : operand is interpreted as signed
//   a_mag, b_mag   : operand magnitudes
//   a_neg, b_neg   : operand is negative
//   raw_in, neg_in : unsigned 2*XLEN result and whether it must be negated
//   fix_out        : sign-corrected 2*XLEN result
module muldiv_signfix
    import muldiv_unit_pkg::*;
#(
    parameter int unsigned XLEN = DEFAULT_XLEN
) (
    input  logic [XLEN-1:0]   a_in,
    input  logic [XLEN-1:0]   b_in,
    input  logic              a_sgn,
    input  logic              b_sgn,
    output logic [XLEN-1:0]   a_mag,
    output logic [XLEN-1:0]   b_mag,
    output logic              a_neg,
    output logic              b_neg,
    input  logic [2*XLEN-1:0] raw_in,
    input  logic              neg_in,
    output logic [2*XLEN-1:0] fix_out
);

    always_comb begin
        a_neg   = a_sgn & a_in[XLEN-1];
        b_neg   = b_sgn & b_in[XLEN-1];
        a_mag   = a_neg ? ('0 - a_in) : a_in;
        b_mag   = b_neg ? ('0 - b_in) : b_in;
        fix_out = neg_in ? ('0 - raw_in) : raw_in;
    end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV M-extension multiply/divide unit.
//   clk, rst (sync, active-high), start (accepted in IDLE only),
//   ctl (func3 op select), a/b (rs1/rs2), result, done (1-cycle pulse),
//   busy (not IDLE), illegal (qualifies done for an unsupported op).
// Build option: define MULDIV_DIV_EN to include the divider datapath;
// without it, ctl 100-111 completes via the fast path with result 0 and illegal=1.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int unsigned XLEN = DEFAULT_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      ctl,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result,
    output logic            done,
    output logic            busy,
    output logic            illegal
);

    localparam int unsigned CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_e          state_q, state_d;
    logic [2:0]      ctl_q, ctl_d;
    logic [XLEN-1:0] a_q, a_d, b_q, b_d;
    logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [2:0]      sel_ctl;
    logic [XLEN-1:0] sel_a, sel_b, a_mag, b_mag;
    logic            a_neg, b_neg;
    logic [2*XLEN-1:0] fix_src, fix_out;
    logic            fix_neg;
    logic [XLEN-1:0] fix_res;
    logic [XLEN:0]   mul_sum;
    logic            start_fast;

    // In IDLE the sign unit looks at the incoming operands so the iteration
    // registers can be preloaded with magnitudes on the accepting edge.
    always_comb begin
        sel_ctl = (state_q == ST_IDLE) ? ctl : ctl_q;
        sel_a   = (state_q == ST_IDLE) ? a   : a_q;
        sel_b   = (state_q == ST_IDLE) ? b   : b_q;
    end

    muldiv_signfix #(.XLEN(XLEN)) u_signfix (
        .a_in    (sel_a),
        .b_in    (sel_b),
        .a_sgn   (a_is_signed(sel_ctl)),
        .b_sgn   (b_is_signed(sel_ctl)),
        .a_mag   (a_mag),
        .b_mag   (b_mag),
        .a_neg   (a_neg),
        .b_neg   (b_neg),
        .raw_in  (fix_src),
        .neg_in  (fix_neg),
        .fix_out (fix_out)
    );

    always_comb begin
`ifdef MULDIV_DIV_EN
        start_fast = ctl[2] && ((b == '0) || (!ctl[0] && (a == MOST_NEG) && (b == '1)));
`else
        start_fast = ctl[2];
`endif
    end

    // State register and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ctl_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            ctl_q    <= ctl_d;
            a_q      <= a_d;
            b_q      <= b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start) state_d = start_fast ? ST_FIX : ST_CALC;
            ST_CALC: if (cnt_q == CW'(XLEN - 1)) state_d = ST_FIX;
            ST_FIX:  state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Iteration datapath: multiply keeps {hi,lo} as a right-shifting
    // accumulator/multiplier pair; divide keeps remainder in hi and shifts
    // quotient bits into lo from the bottom.
    always_comb begin
        ctl_d = ctl_q;
        a_d   = a_q;
        b_d   = b_q;
        hi_d  = hi_q;
        lo_d  = lo_q;
        cnt_d = cnt_q;
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_mag} : '0);
`ifdef MULDIV_DIV_EN
        begin : div_step
            logic [XLEN:0] div_shift, div_diff;
            div_shift = {hi_q, lo_q[XLEN-1]};
            div_diff  = div_shift - {1'b0, b_mag};
            if (state_q == ST_CALC && ctl_q[2]) begin
                hi_d = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
                lo_d = {lo_q[XLEN-2:0], ~div_diff[XLEN]};
            end
        end
`endif
        if (state_q == ST_IDLE && start) begin
            ctl_d = ctl;
            a_d   = a;
            b_d   = b;
            cnt_d = '0;
            hi_d  = '0;
            lo_d  = ctl[2] ? a_mag : b_mag;
        end else if (state_q == ST_CALC) begin
            cnt_d = cnt_q + CW'(1);
            if (!ctl_q[2]) begin
                hi_d = mul_sum[XLEN:1];
                lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
            end
        end
    end

    // Sign correction and output selection, applied in FIX.
    always_comb begin
        fix_src = {hi_q, lo_q};
        fix_neg = a_neg ^ b_neg;
`ifdef MULDIV_DIV_EN
        if (ctl_q[2]) begin
            if (ctl_q[1]) begin
                fix_src = {{XLEN{1'b0}}, hi_q};
                fix_neg = a_neg;
            end else begin
                fix_src = {{XLEN{1'b0}}, lo_q};
            end
        end
`endif
        fix_res = (!ctl_q[2] && (ctl_q != CTL_MUL)) ? fix_out[2*XLEN-1:XLEN] : fix_out[XLEN-1:0];
        if (ctl_q[2]) begin
`ifdef MULDIV_DIV_EN
            if (b_q == '0) begin
                fix_res = ctl_q[1] ? a_q : '1;
            end else if (!ctl_q[0] && (a_q == MOST_NEG) && (b_q == '1)) begin
                fix_res = ctl_q[1] ? '0 : a_q;
            end
`else
            fix_res = '0;
`endif
        end
        result_d = (state_q == ST_FIX) ? fix_res : result_q;
    end

    // Outputs.
    always_comb begin
        busy   = (state_q != ST_IDLE);
        done   = (state_q == ST_DONE);
        result = result_q;
`ifdef MULDIV_DIV_EN
        illegal = 1'b0;
`else
        illegal = (state_q == ST_DONE) && ctl_q[2];
`endif
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: self-checking bench for muldiv_unit (XLEN=32).
// Expected results come from a plain-arithmetic reference model; the
// divider expectations follow the MULDIV_DIV_EN build option.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [2:0]  ctl;
    logic [31:0] a, b, result;
    logic        done, busy, illegal;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [31:0] prev_res = '0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .ctl     (ctl),
        .a       (a),
        .b       (b),
        .result  (result),
        .done    (done),
        .busy    (busy),
        .illegal (illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit div_en();
`ifdef MULDIV_DIV_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] ref_result(input logic [2:0] c, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, ux, uy;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'({32'h0, x});
        uy = longint'({32'h0, y});
        case (c)
            CTL_MUL:    begin p = sx * sy; return p[31:0];  end
            CTL_MULH:   begin p = sx * sy; return p[63:32]; end
            CTL_MULHSU: begin p = sx * uy; return p[63:32]; end
            CTL_MULHU:  begin p = ux * uy; return p[63:32]; end
            default: begin
                if (!div_en()) return 32'h0;
                if (y == 32'h0) return c[1] ? x : 32'hFFFF_FFFF;
                if (!c[0]) p = c[1] ? sx % sy : sx / sy;
                else       p = c[1] ? ux % uy : ux / uy;
                return p[31:0];
            end
        endcase
    endfunction

    function automatic int unsigned ref_latency(input logic [2:0] c, input logic [31:0] x, input logic [31:0] y);
        if (c[2] && (!div_en() || y == 32'h0 ||
                     (!c[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)))
            return 2;
        return 34;
    endfunction

    task automatic run_op(input logic [2:0] c, input logic [31:0] x, input logic [31:0] y, input bit hold);
        int unsigned k, busy_n, extra, exp_lat;
        bit got;
        logic [31:0] exp_res;
        bit exp_ill;
        for (int i = 0; i < 50 && busy !== 1'b0; i++) begin
            @(posedge clk); #1;
        end
        check("idle before start", 64'(busy), 64'(0));
        exp_res = ref_result(c, x, y);
        exp_lat = ref_latency(c, x, y);
        exp_ill = c[2] && !div_en();
        ctl = c; a = x; b = y; start = 1'b1;
        k = 0; busy_n = 0; got = 1'b0;
        while (!got && k < 100) begin
            @(posedge clk); #1;
            k++;
            if (hold) begin
                ctl = 3'($urandom); a = $urandom; b = $urandom;
            end else begin
                start = 1'b0;
            end
            if (busy === 1'b1) busy_n++;
            if (k == 1) check("result held until fix", 64'(result), 64'(prev_res));
            if (done === 1'b1) got = 1'b1;
        end
        check($sformatf("done seen ctl=%0d", c), 64'(got), 64'(1));
        check($sformatf("latency ctl=%0d", c), 64'(k), 64'(exp_lat));
        check($sformatf("busy cycles ctl=%0d", c), 64'(busy_n), 64'(exp_lat));
        check($sformatf("result ctl=%0d a=%h b=%h", c, x, y), 64'(result), 64'(exp_res));
        check($sformatf("illegal ctl=%0d", c), 64'(illegal), 64'(exp_ill));
        prev_res = exp_res;
        if (hold) begin
            @(posedge clk); #1;
            start = 1'b0;
            check("idle after held start", 64'(busy), 64'(0));
            extra = 0;
            repeat (40) begin
                @(posedge clk); #1;
                if (done === 1'b1) extra++;
            end
            check("no extra done", 64'(extra), 64'(0));
        end
    endtask

    initial begin
        int unsigned extra;
        logic [2:0]  rc;
        logic [31:0] rx, ry;

        rst = 1'b1; start = 1'b0; ctl = '0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset result", 64'(result), 64'(0));
        check("reset done", 64'(done), 64'(0));
        check("reset busy", 64'(busy), 64'(0));
        check("reset illegal", 64'(illegal), 64'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(CTL_MUL,    32'd7,          32'hFFFF_FFFD, 1'b0);
        run_op(CTL_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 1'b0);
        run_op(CTL_MULHSU, 32'hFFFF_FFFF,  32'd2,         1'b0);
        run_op(CTL_DIV,    32'hFFFF_FFF9,  32'd2,         1'b0);
        run_op(CTL_REM,    32'hFFFF_FFF9,  32'd2,         1'b0);
        run_op(CTL_DIVU,   32'd7,          32'd0,         1'b0);
        run_op(CTL_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 1'b0);
        run_op(CTL_REM,    32'h8000_0000,  32'hFFFF_FFFF, 1'b0);
        run_op(CTL_DIV,    32'd9,          32'd3,         1'b0);
        run_op(CTL_MUL,    32'd3,          32'd3,         1'b0);
        run_op(CTL_MULH,   32'h8000_0000,  32'h8000_0000, 1'b0);
        run_op(CTL_MUL,    32'd12345,      32'd678,       1'b1);

        // Abort during CALC cycle 10.
        ctl = CTL_MUL; a = 32'd1000; b = 32'd2000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("busy mid calc", 64'(busy), 64'(1));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort busy", 64'(busy), 64'(0));
        check("abort done", 64'(done), 64'(0));
        check("abort result", 64'(result), 64'(0));
        extra = 0;
        repeat (50) begin
            @(posedge clk); #1;
            if (done === 1'b1) extra++;
        end
        check("no done after abort", 64'(extra), 64'(0));
        prev_res = '0;

        for (int i = 0; i < 30; i++) begin
            rc = 3'($urandom_range(0, 7));
            rx = $urandom;
            ry = $urandom;
            case ($urandom_range(0, 5))
                0: ry = 32'h0;
                1: begin rx = 32'h8000_0000; ry = 32'hFFFF_FFFF; end
                2: begin rx = 32'($signed(8'($urandom))); ry = 32'($signed(4'($urandom))); end
                default: ;
            endcase
            run_op(rc, rx, ry, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL expose parameter XLEN, default 32, operand/result width; legal values 8, 16, 32, 64.
REQ-002 SHALL expose port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL expose port rst, input, 1, reset; synchronous and active-high.
REQ-004 SHALL expose port start, input, 1, request; sampled only in IDLE.
REQ-005 SHALL expose port ctl, input, 3, operation select per M-extension func3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL expose ports a and b, input, XLEN each, rs1 and rs2 operands.
REQ-007 SHALL expose port result, output, XLEN, operation result.
REQ-008 SHALL expose port done, output, 1, one-cycle completion pulse (the exdone source).
REQ-009 SHALL expose port busy, output, 1, high in every state except IDLE.
REQ-010 SHALL expose port illegal, output, 1, qualifies done for an unsupported op.

Function
REQ-011 SHALL implement the FSM states IDLE, CALC, FIX and DONE.
REQ-012 IDLE with start=1 in cycle N SHALL latch ctl, a and b, clear the iteration counter and enter CALC at N+1.
REQ-013 CALC SHALL run exactly XLEN cycles: radix-2 shift-add for multiply, restoring shift-subtract for divide, on magnitudes.
REQ-014 FIX SHALL apply sign correction and select the output: the low or high XLEN bits of the 2*XLEN product, or the quotient or remainder.
REQ-015 DONE SHALL hold done=1 for exactly one cycle at N+XLEN+2, then return to IDLE.
REQ-016 Signedness SHALL be: MULH both operands signed; MULHSU a signed, b unsigned; MULHU, DIVU and REMU unsigned; DIV and REM signed.
REQ-017 Division SHALL truncate toward zero; the remainder SHALL take the sign of the dividend.
REQ-018 Divide by zero SHALL give quotient all-ones and remainder = a, via the fast path IDLE->FIX->DONE with done at N+2.
REQ-019 Signed overflow (a = most-negative, b = -1, DIV or REM) SHALL give quotient = a and remainder 0, via the same fast path.
REQ-020 start while busy=1 SHALL be ignored; latched operands SHALL be unaffected.
REQ-021 result SHALL hold its value from DONE until the FIX of the next operation.
REQ-022 Back-to-back requests SHALL be allowed: start in the cycle after DONE (IDLE) is accepted.

Reset
REQ-023 With rst=1 at a clock edge the unit SHALL enter IDLE with result=0, done=0, busy=0, illegal=0 and counter=0.
REQ-024 rst during CALC, FIX or DONE SHALL abort the operation; no done pulse SHALL follow for the aborted request.

Configuration
REQ-025 Macro MULDIV_DIV_EN SHALL compile in the divider datapath.
REQ-026 With MULDIV_DIV_EN defined, ctl 100-111 SHALL execute per REQ-013..REQ-019 and illegal SHALL remain 0.
REQ-027 Without MULDIV_DIV_EN, ctl 100-111 SHALL take the fast path, giving result=0, done at N+2 and illegal=1 in the DONE cycle only; multiply SHALL be unchanged.

Structure
REQ-028 A shared package SHALL hold the ctl encodings as named constants, the FSM state typedef and the cycle-count constant XLEN+2.
REQ-029 The unit SHALL instantiate one sub-module, muldiv_signfix, which is combinational and performs operand magnitude and result negation.

Verification
REQ-030 XLEN=32, MUL a=7, b=-3: result=0xFFFFFFEB, done exactly 34 cycles after the start cycle, busy high for 34 cycles.
REQ-031 MULHU a=b=0xFFFFFFFF: result=0xFFFFFFFE; MULHSU a=-1, b=2: result=0xFFFFFFFF.
REQ-032 DIV a=-7, b=2: result=0xFFFFFFFD; REM a=-7, b=2: result=0xFFFFFFFF; DIVU a=7, b=0: result=0xFFFFFFFF with done at N+2.
REQ-033 DIV a=0x80000000, b=-1: result=0x80000000; REM with the same operands: result=0; both with done at N+2.
REQ-034 Assert start every cycle through one MUL: exactly one done per accepted request; rst at CALC cycle 10: no done, busy=0 in the next cycle.
REQ-035 Build without MULDIV_DIV_EN, DIV a=9, b=3: result=0, illegal=1, done at N+2; MUL 3*3 still gives 9 with illegal=0.
